// File: rtl/grid_operand_issue.sv
// ============================================================================
// Module      : grid_operand_issue
// Description : Fans one instruction's source operands out to grid IO units,
//               holds them until accepted, and tracks instructions in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_operand_issue #(
    parameter int XLEN           = 32,
    parameter int NUM_READ_PORTS = 5,
    parameter int NUM_IO_UNITS   = 8,
    parameter int MAX_IN_FLIGHT  = 4,
    localparam int SELW = (NUM_IO_UNITS > 1) ? $clog2(NUM_IO_UNITS) : 1,
    localparam int CW   = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [NUM_READ_PORTS*XLEN-1:0]  issue_rs_data_i,
    input  logic [NUM_READ_PORTS-1:0]       issue_rs_used_i,
    input  logic [NUM_READ_PORTS*SELW-1:0]  issue_io_unit_sels_i,
    output logic [NUM_IO_UNITS*XLEN-1:0]    io_unit_input_data_o,
    output logic [NUM_IO_UNITS-1:0]         io_unit_input_valid_o,
    input  logic [NUM_IO_UNITS-1:0]         io_unit_input_ready_i,
    input  logic                            wb_committing_i,
    output logic [CW-1:0]                   in_flight_count_o,
    output logic                            grid_busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [CW-1:0]   C_MAX_IN_FLIGHT = CW'(MAX_IN_FLIGHT);
    localparam logic [SELW:0]   C_NUM_IO_UNITS  = (SELW+1)'(NUM_IO_UNITS);

    state_e                             state_q, state_d;
    logic [NUM_IO_UNITS-1:0]            pend_q, pend_d;
    logic [NUM_IO_UNITS-1:0][XLEN-1:0]  data_q, data_d;
    logic [CW-1:0]                      count_q, count_d;
    logic [SELW-1:0]                    sel_w;
    logic                               accept_w;

    // Ready depends only on registered state and reset, never on IO-unit ready.
    assign issue_ready_o = !rst && (state_q == ST_IDLE) && (count_q < C_MAX_IN_FLIGHT);
    assign accept_w      = issue_valid_i && issue_ready_o;

    // Ports are scanned high to low so the lowest used port claiming a unit wins.
    always_comb begin : operand_load
        pend_d = pend_q & ~io_unit_input_ready_i;
        data_d = data_q;
        sel_w  = '0;
        if (accept_w) begin
            for (int p = NUM_READ_PORTS - 1; p >= 0; p--) begin
                sel_w = issue_io_unit_sels_i[p*SELW +: SELW];
                if (issue_rs_used_i[p] && ({1'b0, sel_w} < C_NUM_IO_UNITS)) begin
                    pend_d[sel_w] = 1'b1;
                    data_d[sel_w] = issue_rs_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_w && (pend_d != '0)) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (pend_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit with count at zero is dropped; accept and commit together cancel.
    always_comb begin : count_next
        count_d = count_q;
        if (accept_w && !wb_committing_i) begin
            count_d = count_q + CW'(1);
        end else if (!accept_w && wb_committing_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign io_unit_input_valid_o = pend_q;
    assign io_unit_input_data_o  = data_q;
    assign in_flight_count_o     = count_q;
    assign grid_busy_o           = (state_q == ST_DRIVE) || (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_grid_operand_issue.sv
// ============================================================================
// Module      : tb_grid_operand_issue
// Description : Directed self-checking bench with a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_operand_issue;

    localparam int XLEN = 32;
    localparam int NRP  = 5;
    localparam int NIO  = 8;
    localparam int MAXF = 4;
    localparam int SELW = 3;
    localparam int CW   = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  issue_valid = 1'b0;
    logic                  issue_ready;
    logic [NRP*XLEN-1:0]   rs_data = '0;
    logic [NRP-1:0]        used = '0;
    logic [NRP*SELW-1:0]   sels = '0;
    logic [NIO*XLEN-1:0]   io_data;
    logic [NIO-1:0]        io_valid;
    logic [NIO-1:0]        io_ready = '0;
    logic                  wb = 1'b0;
    logic [CW-1:0]         cnt;
    logic                  busy;

    logic [NIO-1:0]            m_pend = '0;
    logic [NIO-1:0][XLEN-1:0]  m_data = '0;
    int                        m_count = 0;
    bit                        chk_en = 1'b0;
    int                        n_tests = 0;
    int                        n_fail = 0;

    grid_operand_issue #(
        .XLEN(XLEN), .NUM_READ_PORTS(NRP), .NUM_IO_UNITS(NIO), .MAX_IN_FLIGHT(MAXF)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .issue_valid_i         (issue_valid),
        .issue_ready_o         (issue_ready),
        .issue_rs_data_i       (rs_data),
        .issue_rs_used_i       (used),
        .issue_io_unit_sels_i  (sels),
        .io_unit_input_data_o  (io_data),
        .io_unit_input_valid_o (io_valid),
        .io_unit_input_ready_i (io_ready),
        .wb_committing_i       (wb),
        .in_flight_count_o     (cnt),
        .grid_busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: operands pending per unit, a plain in-flight counter.
    function automatic bit f_ready();
        return !rst && (m_pend == '0) && (m_count < MAXF);
    endfunction

    function automatic bit f_accept();
        return issue_valid && f_ready();
    endfunction

    function automatic logic [NIO-1:0] f_npend();
        logic [NIO-1:0] np;
        if (rst) return '0;
        np = m_pend & ~io_ready;
        if (f_accept())
            for (int p = 0; p < NRP; p++)
                if (used[p]) np[sels[p*SELW +: SELW]] = 1'b1;
        return np;
    endfunction

    function automatic logic [NIO-1:0][XLEN-1:0] f_ndata();
        logic [NIO-1:0][XLEN-1:0] d;
        logic [NIO-1:0]           claimed;
        if (rst) return '0;
        d       = m_data;
        claimed = '0;
        if (f_accept())
            for (int p = 0; p < NRP; p++)
                if (used[p] && !claimed[sels[p*SELW +: SELW]]) begin
                    claimed[sels[p*SELW +: SELW]] = 1'b1;
                    d[sels[p*SELW +: SELW]]       = rs_data[p*XLEN +: XLEN];
                end
        return d;
    endfunction

    function automatic int f_ncount();
        bit a;
        if (rst) return 0;
        a = f_accept();
        if (a && !wb) return m_count + 1;
        if (!a && wb && m_count > 0) return m_count - 1;
        return m_count;
    endfunction

    always @(posedge clk) begin
        m_pend  <= f_npend();
        m_data  <= f_ndata();
        m_count <= f_ncount();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", 64'(issue_ready), 64'(f_ready()));
            chk("cyc_valid", 64'(io_valid), 64'(m_pend));
            for (int u = 0; u < NIO; u++)
                chk($sformatf("cyc_data%0d", u), 64'(io_data[u*XLEN +: XLEN]), 64'(m_data[u]));
            chk("cyc_count", 64'(cnt), 64'(m_count));
            chk("cyc_busy", 64'(busy), 64'((m_pend != '0) || (m_count != 0)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [SELW-1:0] s, input logic [XLEN-1:0] d);
        sels[p*SELW +: SELW]    = s;
        rs_data[p*XLEN +: XLEN] = d;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        chk("rst_valid", 64'(io_valid), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h0);
        chk("rst_count", 64'(cnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(issue_ready), 64'h1);

        // Basic fan-out
        io_ready = 8'hFF;
        set_port(0, 3'd2, 32'hAAAA0001);
        set_port(1, 3'd5, 32'hBBBB0002);
        used = 5'b00011;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("fan_valid", 64'(io_valid), 64'h24);
        chk("fan_d2", 64'(io_data[2*XLEN +: XLEN]), 64'hAAAA0001);
        chk("fan_d5", 64'(io_data[5*XLEN +: XLEN]), 64'hBBBB0002);
        chk("fan_ready_low", 64'(issue_ready), 64'h0);
        step();
        chk("fan_clear", 64'(io_valid), 64'h0);
        chk("fan_ready", 64'(issue_ready), 64'h1);
        chk("fan_count", 64'(cnt), 64'h1);

        // Staggered ready: unit 5 held off for three cycles
        io_ready = 8'hDF;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("stag_valid", 64'(io_valid), 64'h24);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stag_hold_valid", 64'(io_valid), 64'h20);
            chk("stag_hold_d5", 64'(io_data[5*XLEN +: XLEN]), 64'hBBBB0002);
            chk("stag_hold_ready", 64'(issue_ready), 64'h0);
        end
        io_ready = 8'hFF;
        #1;
        chk("stag_no_comb_path", 64'(issue_ready), 64'h0);
        step();
        chk("stag_ready", 64'(issue_ready), 64'h1);
        chk("stag_valid_clr", 64'(io_valid), 64'h0);
        chk("stag_count", 64'(cnt), 64'h2);

        // Duplicate select: lowest port wins
        set_port(0, 3'd3, 32'h11);
        set_port(1, 3'd3, 32'h33);
        set_port(2, 3'd3, 32'h22);
        used = 5'b00101;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("dup_valid", 64'(io_valid), 64'h08);
        chk("dup_d3", 64'(io_data[3*XLEN +: XLEN]), 64'h11);
        chk("dup_hold_d2", 64'(io_data[2*XLEN +: XLEN]), 64'hAAAA0001);
        step();
        chk("dup_count", 64'(cnt), 64'h3);

        // Drain and underflow guard
        wb = 1'b1;
        step(); step(); step();
        chk("drain_count", 64'(cnt), 64'h0);
        step();
        wb = 1'b0;
        chk("uf_count", 64'(cnt), 64'h0);
        chk("uf_busy", 64'(busy), 64'h0);

        // Back-pressure with zero-operand instructions
        used = 5'b00000;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("bp_count", 64'(cnt), 64'h4);
        chk("bp_ready", 64'(issue_ready), 64'h0);
        chk("bp_busy", 64'(busy), 64'h1);
        issue_valid = 1'b0;
        wb = 1'b1;
        step();
        wb = 1'b0;
        chk("bp_commit_count", 64'(cnt), 64'h3);
        chk("bp_commit_ready", 64'(issue_ready), 64'h1);
        issue_valid = 1'b1;
        wb = 1'b1;
        step();
        issue_valid = 1'b0;
        wb = 1'b0;
        chk("bp_both_count", 64'(cnt), 64'h3);

        // Reset while driving
        io_ready = 8'h00;
        set_port(0, 3'd5, 32'hCAFE0005);
        used = 5'b00001;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("rm_valid", 64'(io_valid), 64'h20);
        chk("rm_count", 64'(cnt), 64'h4);
        chk("rm_d5", 64'(io_data[5*XLEN +: XLEN]), 64'hCAFE0005);
        rst = 1'b1;
        step();
        chk("rm_rst_valid", 64'(io_valid), 64'h0);
        chk("rm_rst_count", 64'(cnt), 64'h0);
        chk("rm_rst_busy", 64'(busy), 64'h0);
        chk("rm_rst_ready", 64'(issue_ready), 64'h0);
        for (int u = 0; u < NIO; u++)
            chk("rm_rst_data", 64'(io_data[u*XLEN +: XLEN]), 64'h0);
        rst = 1'b0;
        step();
        chk("rm_ready_after", 64'(issue_ready), 64'h1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
